// File: rtl/cdu_read_counter.sv
// CDU read counter: accumulates fine/coarse step requests into the angle register and
// meters the change out to the AGC as rate-limited +/- count pulses.
module cdu_read_counter #(
  parameter int CNT_W     = 16,
  parameter int CRS_SHIFT = 6,
  parameter int PEND_W    = 12,
  parameter int PULSE_CYC = 4
) (
  input  logic             CLOCKH,
  input  logic             rst_n,
  input  logic             PS25KH,
  input  logic             _800LHI,
  input  logic             UPLVL,
  input  logic             DNLVL,
  input  logic             TPF1,
  input  logic             TPC1,
  input  logic             CDUZ,
  output logic [CNT_W-1:0] READ_CNT,
  output logic             CDUP,
  output logic             CDUM,
  output logic             BUSY,
  output logic             OVF
);

  // Working width holds PEND + delta - sent without overflow before clamping.
  localparam int SUM_W = ((PEND_W > CNT_W) ? PEND_W : CNT_W) + 3;
  localparam int CW    = $clog2(PULSE_CYC + 1);
  localparam logic signed [SUM_W-1:0] PMAX_S = SUM_W'((64'sd1 <<< (PEND_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] NMIN_S = -PMAX_S;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLUS  = 2'd1,
    MINUS = 2'd2
  } state_t;

  function automatic logic [PEND_W-1:0] sat_pend(input logic signed [SUM_W-1:0] v);
    logic [PEND_W-1:0] r;
    if (v > PMAX_S) begin
      r = PMAX_S[PEND_W-1:0];
    end else if (v < NMIN_S) begin
      r = NMIN_S[PEND_W-1:0];
    end else begin
      r = v[PEND_W-1:0];
    end
    return r;
  endfunction

  state_t                   state_r, state_nxt_s;
  logic [CW-1:0]            cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0]         read_cnt_r, read_nxt_s;
  logic [PEND_W-1:0]        pend_r, pend_nxt_s;
  logic                     cdup_r, cdum_r, busy_r, ovf_r;
  logic                     cdup_nxt_s, cdum_nxt_s, busy_nxt_s, ovf_nxt_s, ovf_hit_s;
  logic                     pend_pos_s, pend_neg_s, start_up_s, start_dn_s;
  logic signed [SUM_W-1:0]  mag_s, delta_s, sent_s, pend_sum_s;

  // Step delta, pending-count update, and pulse sequencing for the next edge.
  always_comb begin
    mag_s       = SUM_W'(TPF1) + (SUM_W'(TPC1) << CRS_SHIFT);
    delta_s     = {SUM_W{1'b0}};
    sent_s      = {SUM_W{1'b0}};
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;

    if (PS25KH && UPLVL && !DNLVL) begin
      delta_s = mag_s;
    end else if (PS25KH && DNLVL && !UPLVL) begin
      delta_s = -mag_s;
    end else begin
      delta_s = {SUM_W{1'b0}};
    end

    // Pulse decision looks at the registered PEND, before this cycle's delta.
    pend_neg_s = pend_r[PEND_W-1];
    pend_pos_s = !pend_r[PEND_W-1] && (pend_r != {PEND_W{1'b0}});
    start_up_s = (state_r == IDLE) && _800LHI && !CDUZ && pend_pos_s;
    start_dn_s = (state_r == IDLE) && _800LHI && !CDUZ && pend_neg_s;

    if (start_up_s) begin
      sent_s = SUM_W'(1);
    end else if (start_dn_s) begin
      sent_s = {SUM_W{1'b1}};
    end else begin
      sent_s = {SUM_W{1'b0}};
    end

    case (state_r)
      IDLE: begin
        if (start_up_s) begin
          state_nxt_s = PLUS;
          cnt_nxt_s   = {CW{1'b0}};
        end else if (start_dn_s) begin
          state_nxt_s = MINUS;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end
      end
      PLUS, MINUS: begin
        if (cnt_r == CW'(PULSE_CYC - 1)) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          state_nxt_s = state_r;
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase

    pend_sum_s = SUM_W'($signed(pend_r)) + delta_s - sent_s;
    ovf_hit_s  = (pend_sum_s > PMAX_S) || (pend_sum_s < NMIN_S);

    // Zero command discards this cycle's delta; an in-flight pulse still finishes.
    if (CDUZ) begin
      read_nxt_s = {CNT_W{1'b0}};
      pend_nxt_s = {PEND_W{1'b0}};
      ovf_nxt_s  = 1'b0;
    end else begin
      read_nxt_s = read_cnt_r + delta_s[CNT_W-1:0];
      pend_nxt_s = sat_pend(pend_sum_s);
      ovf_nxt_s  = ovf_r | ovf_hit_s;
    end

    cdup_nxt_s = (state_nxt_s == PLUS);
    cdum_nxt_s = (state_nxt_s == MINUS);
    busy_nxt_s = (pend_nxt_s != {PEND_W{1'b0}}) || (state_nxt_s != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      read_cnt_r <= {CNT_W{1'b0}};
      pend_r     <= {PEND_W{1'b0}};
      cdup_r     <= 1'b0;
      cdum_r     <= 1'b0;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      read_cnt_r <= read_nxt_s;
      pend_r     <= pend_nxt_s;
      cdup_r     <= cdup_nxt_s;
      cdum_r     <= cdum_nxt_s;
      busy_r     <= busy_nxt_s;
      ovf_r      <= ovf_nxt_s;
    end
  end

  assign READ_CNT = read_cnt_r;
  assign CDUP     = cdup_r;
  assign CDUM     = cdum_r;
  assign BUSY     = busy_r;
  assign OVF      = ovf_r;

endmodule
